// File: rtl/fetch_seq.sv
// fetch_seq -- instruction-fetch sequencer.
//
// Owns the PC and issues in-order word fetches to instruction memory. It
// buffers the in-order responses in a small {pc, instr} FIFO and presents
// them to ID. A redirect flushes the FIFO. Responses that are still in
// flight at the time of a redirect are dropped while the FSM is in DRAIN.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   imem_req_valid/_ready/_addr   fetch request (addr = current PC)
//   imem_rsp_valid/_data          in-order response, no back-pressure
//   redirect_valid/_pc            branch/jump redirect
//   id_valid/_ready, id_pc/_instr instruction toward decode
//   misalign_err                  sticky misaligned-redirect flag
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to make misalign_err live.
// When it is undefined, the low PC bits of a redirect are silently cleared
// and misalign_err is tied low.
module fetch_seq #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        misalign_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_START, S_FETCH, S_DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]                occ_q, occ_d, outst_q, outst_d;
  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [FIFO_DEPTH-1:0][31:0]  fpc_q, finstr_q;

  logic        req_hs, rsp_ok, push, pop;
  logic [31:0] tgt;
  logic [CW:0] credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign tgt         = {redirect_pc[31:2], 2'b00};
  assign credit_used = {1'b0, occ_q} + {1'b0, outst_q};
  // Credits are counted, not FIFO space, so a response always has room.
  // Deliberately independent of redirect_valid and imem_req_ready.
  assign imem_req_valid = (state_q == S_FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign id_valid       = (occ_q != '0);
  assign id_pc          = fpc_q[head_q];
  assign id_instr       = finstr_q[head_q];

  assign req_hs = imem_req_valid & imem_req_ready;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rsp_ok = imem_rsp_valid & (outst_q != '0);
  assign push   = rsp_ok & (state_q == S_FETCH) & ~redirect_valid;
  assign pop    = id_valid & id_ready & ~redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    occ_d    = occ_q;
    head_d   = head_q;
    tail_d   = tail_q;
    outst_d  = outst_q;

    // Dropped responses (redirect cycle or DRAIN) still retire a credit.
    if (req_hs) outst_d = outst_d + CW'(1);
    if (rsp_ok) outst_d = outst_d - CW'(1);

    if (redirect_valid) begin
      pc_d     = tgt;
      rsp_pc_d = tgt;
      occ_d    = '0;
      head_d   = '0;
      tail_d   = '0;
      state_d  = (outst_d != '0) ? S_DRAIN : S_FETCH;
    end else begin
      if (req_hs) pc_d = pc_q + 32'd4;
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        tail_d   = ptr_inc(tail_q);
      end
      if (pop) head_d = ptr_inc(head_q);
      if (push && !pop)      occ_d = occ_q + CW'(1);
      else if (!push && pop) occ_d = occ_q - CW'(1);
      unique case (state_q)
        S_START: state_d = S_FETCH;
        S_FETCH: state_d = S_FETCH;
        S_DRAIN: state_d = (outst_d == '0) ? S_FETCH : S_DRAIN;
        default: state_d = S_START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_START;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      occ_q    <= '0;
      outst_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fpc_q    <= '0;
      finstr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      if (push) begin
        fpc_q[tail_q]    <= rsp_pc_q;
        finstr_q[tail_q] <= imem_rsp_data;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign_d   = misalign_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
  assign misalign_err = misalign_q;
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  logic unused_lsb;
  assign unused_lsb   = ^redirect_pc[1:0];
  assign misalign_err = 1'b0;
`endif

endmodule
